// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller: CPU clock-enable sequencer for the single-cycle MIPS board.
// Selects a divided clock, full speed or manual single-step and emits a one-clk-wide
// cpu_en pulse per CPU cycle, with run/pause/halt control.
// Optional feature: define CYCLE_LIMIT_EN to add the max_cycles input, which pauses
// RUN once cycle_count reaches the programmed value (0 disables the limit).
module cpu_clock_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W           = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       div_clk,
   input  logic [2:0]       mode_sel,
   input  logic             run_btn,
   input  logic             step_btn,
   input  logic             halt,
`ifdef CYCLE_LIMIT_EN
   input  logic [CNT_W-1:0] max_cycles,
`endif
   output logic             cpu_en,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [1:0] {PAUSE, RUN, STEP_WAIT, HALTED} state_t;

   localparam int unsigned      DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [3:0]       div_s1_q, div_s2_q;
   logic [2:0]       mode_s1_q, mode_s2_q, mode_prev_q;
   logic             run_s1_q, run_s2_q, step_s1_q, step_s2_q;
   logic             halt_s1_q, halt_s2_q;
   logic             run_db_q, run_db_d, run_db_prev_q;
   logic             step_db_q, step_db_d, step_db_prev_q;
   logic [DB_W-1:0]  run_cnt_q, run_cnt_d, step_cnt_q, step_cnt_d;
   logic             div_prev_q, sel_bit, div_edge;
   logic             mode_is_step, mode_is_full, run_press, step_press, limit_hit;
   state_t           state_q, state_d;
   logic             pulse_d, cpu_en_q, running_q, halted_q;
   logic [CNT_W-1:0] cycle_count_q;

   // Next {level, counter} of a debouncer: level follows raw only after
   // DEBOUNCE_CYCLES consecutive cycles of disagreement.
   function automatic logic [DB_W:0] debounce_next(input logic raw, input logic level,
                                                   input logic [DB_W-1:0] cnt);
      logic [DB_W:0] r;
      r = {level, {DB_W{1'b0}}};
      if (raw != level) begin
         if (cnt == DB_LAST) r = {raw, {DB_W{1'b0}}};
         else                r = {level, cnt + 1'b1};
      end
      return r;
   endfunction

   // Two-flop synchronizers for every asynchronous input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_s1_q  <= '0;
         div_s2_q  <= '0;
         mode_s1_q <= '0;
         mode_s2_q <= '0;
         run_s1_q  <= 1'b0;
         run_s2_q  <= 1'b0;
         step_s1_q <= 1'b0;
         step_s2_q <= 1'b0;
         halt_s1_q <= 1'b0;
         halt_s2_q <= 1'b0;
      end else begin
         div_s1_q  <= div_clk;
         div_s2_q  <= div_s1_q;
         mode_s1_q <= mode_sel;
         mode_s2_q <= mode_s1_q;
         run_s1_q  <= run_btn;
         run_s2_q  <= run_s1_q;
         step_s1_q <= step_btn;
         step_s2_q <= step_s1_q;
         halt_s1_q <= halt;
         halt_s2_q <= halt_s1_q;
      end
   end

   // Debouncer next-state for both buttons.
   always_comb begin
      {run_db_d, run_cnt_d}   = debounce_next(run_s2_q, run_db_q, run_cnt_q);
      {step_db_d, step_cnt_d} = debounce_next(step_s2_q, step_db_q, step_cnt_q);
   end

   // Debounced levels, their previous values, and divided-clock edge history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_db_q       <= 1'b0;
         run_cnt_q      <= '0;
         run_db_prev_q  <= 1'b0;
         step_db_q      <= 1'b0;
         step_cnt_q     <= '0;
         step_db_prev_q <= 1'b0;
         div_prev_q     <= 1'b0;
         mode_prev_q    <= '0;
      end else begin
         run_db_q       <= run_db_d;
         run_cnt_q      <= run_cnt_d;
         run_db_prev_q  <= run_db_q;
         step_db_q      <= step_db_d;
         step_cnt_q     <= step_cnt_d;
         step_db_prev_q <= step_db_q;
         div_prev_q     <= sel_bit;
         mode_prev_q    <= mode_s2_q;
      end
   end

   // Divided-clock source selection.
   always_comb begin
      sel_bit = 1'b0;
      case (mode_s2_q)
         3'd1:    sel_bit = div_s2_q[0];
         3'd2:    sel_bit = div_s2_q[1];
         3'd3:    sel_bit = div_s2_q[2];
         3'd4:    sel_bit = div_s2_q[3];
         default: sel_bit = 1'b0;
      endcase
   end

   // prev holds the old source's level for one cycle after a mode change; masking the
   // edge in that cycle is equivalent to reloading prev from the newly selected bit.
   assign div_edge     = sel_bit & ~div_prev_q & (mode_s2_q == mode_prev_q);
   assign mode_is_step = (mode_s2_q == 3'd0) || (mode_s2_q >= 3'd6);
   assign mode_is_full = (mode_s2_q == 3'd5);
   assign run_press    = run_db_q & ~run_db_prev_q;
   assign step_press   = step_db_q & ~step_db_prev_q;

`ifdef CYCLE_LIMIT_EN
   assign limit_hit = (max_cycles != '0) && cpu_en_q && ((cycle_count_q + CNT_ONE) == max_cycles);
`else
   assign limit_hit = 1'b0;
`endif

   // FSM next state and pulse request; halt overrides everything.
   always_comb begin
      state_d = state_q;
      pulse_d = 1'b0;
      case (state_q)
         PAUSE: begin
            if (run_press && !mode_is_step) begin
               state_d = RUN;
            end else if (step_press) begin
               pulse_d = 1'b1;
               state_d = STEP_WAIT;
            end
         end
         STEP_WAIT: begin
            if (!step_db_q) state_d = PAUSE;
         end
         RUN: begin
            if (run_press || mode_is_step || limit_hit) state_d = PAUSE;
            else if (mode_is_full)                      pulse_d = 1'b1;
            else                                        pulse_d = div_edge;
         end
         HALTED: state_d = HALTED;
         default: state_d = PAUSE;
      endcase
      if (halt_s2_q) state_d = HALTED;
      // Masking on the first stage too keeps cpu_en low in the cycle sync halt rises.
      if (halt_s1_q || halt_s2_q) pulse_d = 1'b0;
   end

   // State register, registered outputs and the pulse counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= PAUSE;
         cpu_en_q      <= 1'b0;
         running_q     <= 1'b0;
         halted_q      <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         state_q   <= state_d;
         cpu_en_q  <= pulse_d;
         running_q <= (state_d == RUN);
         halted_q  <= (state_d == HALTED);
         if (cpu_en_q) cycle_count_q <= cycle_count_q + CNT_ONE;
      end
   end

   assign cpu_en      = cpu_en_q;
   assign running     = running_q;
   assign halted      = halted_q;
   assign cycle_count = cycle_count_q;

endmodule
